// File: rtl/l1d_sram_pkg.sv
// Shared core package for the L1 data SRAM: FSM states, request-entry layout
// and the enable/zero-word constants.
package l1d_sram_pkg;

    localparam logic        L1D_EN        = 1'b1;
    localparam logic [31:0] L1D_ZERO_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_RESP  = 2'd3
    } l1d_state_e;

    typedef struct packed {
        logic        re;
        logic        we;
        logic [31:0] raddr;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } l1d_req_t;

    localparam int L1D_REQ_W = $bits(l1d_req_t);

    function automatic logic [31:0] l1d_strb_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage

// File: rtl/l1d_req_fifo.sv
// Request queue for l1d_sram; full/empty come straight from the registered
// count so a same-cycle pop never makes room for a push.
module l1d_req_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_buf [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [PW:0]      r_cnt;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_cnt == (PW+1)'(DEPTH));
    assign o_empty   = (r_cnt == '0);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_dout    = r_buf[r_rptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_buf[r_wptr] <= i_din;
    end

endmodule

// File: rtl/l1d_sram.sv
// L1 data SRAM with a small request queue and a write-then-read sequencer.
// Optional macro L1D_RANGE_CHECK_EN: out-of-range addresses error/suppress.
//
// state    | meaning
// IDLE     | waiting for a queued request
// WRITE    | masked array write of the current entry at exit edge
// READ     | array word registered into rdata at exit edge
// RESP     | rvalid_o high for this one cycle
module l1d_sram
    import l1d_sram_pkg::*;
#(
    parameter int AW = 10,
    parameter int QD = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        re_i,
    input  logic [31:0] raddr_i,
    input  logic        we_i,
    input  logic [31:0] waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    output logic        req_ready_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        rerr_o,
    output logic        ovf_o
);

    l1d_state_e    r_state;
    l1d_state_e    w_state_nxt;
    l1d_req_t      r_cur;
    l1d_req_t      w_head;
    l1d_req_t      w_push_data;
    logic [31:0]   r_mem [2**AW];
    logic [31:0]   r_rdata;
    logic          r_ovf;
    logic          w_req;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic          w_wr_en;
    logic          w_rd_bad;
    logic          w_wr_bad;
    logic          w_unused;
    logic [AW-1:0] w_widx;
    logic [AW-1:0] w_ridx;
    logic [31:0]   w_mask;

    assign w_req       = re_i | we_i;
    assign req_ready_o = ~w_full;
    assign w_push_data = '{re: re_i, we: we_i, raddr: raddr_i, waddr: waddr_i,
                           wdata: wdata_i, wstrb: wstrb_i};

    l1d_req_fifo #(
        .DEPTH (QD),
        .WIDTH (L1D_REQ_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_req),
        .i_din   (w_push_data),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE:  w_pop = ~w_empty;
            ST_WRITE: begin
                if (r_cur.re)      w_state_nxt = ST_READ;
                else if (!w_empty) w_pop = 1'b1;
                else               w_state_nxt = ST_IDLE;
            end
            ST_READ:  w_state_nxt = ST_RESP;
            ST_RESP: begin
                if (!w_empty) w_pop = 1'b1;
                else          w_state_nxt = ST_IDLE;
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (w_pop) w_state_nxt = w_head.we ? ST_WRITE : ST_READ;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cur   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop)          r_cur <= w_head;
            if (w_req & w_full) r_ovf <= L1D_EN;
        end
    end

    assign w_widx  = r_cur.waddr[AW+1:2];
    assign w_ridx  = r_cur.raddr[AW+1:2];
    assign w_mask  = l1d_strb_mask(r_cur.wstrb);
    assign w_wr_en = (r_state == ST_WRITE) & ~w_wr_bad;

    // Array has no reset; only the output register is cleared.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[w_widx] <= (r_mem[w_widx] & ~w_mask) | (r_cur.wdata & w_mask);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= L1D_ZERO_WORD;
        end else if (r_state == ST_READ) begin
            r_rdata <= w_rd_bad ? L1D_ZERO_WORD : r_mem[w_ridx];
        end
    end

`ifdef L1D_RANGE_CHECK_EN
    logic r_rerr;

    assign w_rd_bad = |r_cur.raddr[31:AW+2];
    assign w_wr_bad = |r_cur.waddr[31:AW+2];
    assign w_unused = ^{r_cur.raddr[1:0], r_cur.waddr[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                    r_rerr <= 1'b0;
        else if (r_state == ST_READ) r_rerr <= w_rd_bad;
    end

    assign rerr_o = r_rerr;
`else
    assign w_rd_bad = 1'b0;
    assign w_wr_bad = 1'b0;
    assign w_unused = ^{r_cur.raddr[31:AW+2], r_cur.raddr[1:0],
                        r_cur.waddr[31:AW+2], r_cur.waddr[1:0]};
    assign rerr_o   = 1'b0;
`endif

    assign rvalid_o = (r_state == ST_RESP);
    assign rdata_o  = r_rdata;
    assign ovf_o    = r_ovf;

endmodule
